// File: rtl/i2c_pkg.sv
// +--------------------------------------------------------------------------+
// | i2c_pkg : shared state encoding and constants for the I2C target.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX_BYTE   = 3'd3,
      RX_ACK    = 3'd4,
      TX_BYTE   = 3'd5,
      TX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } i2c_state_t;

   localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;
   localparam int         I2C_BITCNT_W     = 4;

endpackage

`default_nettype wire

// File: rtl/i2c_line_conditioner.sv
// +--------------------------------------------------------------------------+
// | i2c_line_conditioner : SCL/SDA synchroniser, optional glitch filter      |
// | (macro I2C_GLITCH_FILTER_EN) and SCL-edge / START / STOP detection.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2c_line_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

`ifdef I2C_GLITCH_FILTER_EN
   localparam bit C_FILTER_ON = 1'b1;
`else
   localparam bit C_FILTER_ON = 1'b0;
`endif

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic [1:0]             w_sync;      // [1] = SCL, [0] = SDA
   logic [1:0]             w_line;
   logic [1:0]             r_line_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      end
   end

   assign w_sync = {r_scl_sync[SYNC_STAGES-1], r_sda_sync[SYNC_STAGES-1]};

   if (C_FILTER_ON && FILTER_LEN > 1) begin : g_filter
      localparam int C_CNT_W = $clog2(FILTER_LEN);
      logic [1:0]         r_filt;
      logic [C_CNT_W-1:0] r_cnt [2];

      // A line flips only after FILTER_LEN consecutive samples disagree with it.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_filt <= 2'b11;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (w_sync[i] == r_filt[i]) begin
                  r_cnt[i] <= '0;
               end else if (r_cnt[i] == C_CNT_W'(FILTER_LEN - 1)) begin
                  r_filt[i] <= w_sync[i];
                  r_cnt[i]  <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 1'b1;
               end
            end
         end
      end
      assign w_line = r_filt;
   end else begin : g_bypass
      assign w_line = w_sync;
   end

   always_ff @(posedge clk) begin
      if (reset) r_line_d <= 2'b11;
      else       r_line_d <= w_line;
   end

   assign o_sda      = w_line[0];
   assign o_scl_rise =  w_line[1] & ~r_line_d[1];
   assign o_scl_fall = ~w_line[1] &  r_line_d[1];
   assign o_start    =  w_line[1] &  r_line_d[1] &  r_line_d[0] & ~w_line[0];
   assign o_stop     =  w_line[1] &  r_line_d[1] & ~r_line_d[0] &  w_line[0];

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// +--------------------------------------------------------------------------+
// | i2c_target : addressed I2C responder with pulse/strobe fabric handshake. |
// | Optional glitch filter via macro I2C_GLITCH_FILTER_EN.  Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2c_target
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   output logic       sda_oe,
   input  logic [6:0] own_address,
   input  logic       rx_ack_en,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic       read_write,
   output logic       busy,
   output logic       start_det,
   output logic       stop_det
);

   logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;

   i2c_state_t              r_state;
   logic [I2C_BITCNT_W-1:0] r_bitcnt;
   logic [7:0]              r_shift;
   logic [7:0]              r_rx_data;
   logic r_sda_oe, r_rx_valid, r_tx_load, r_rw, r_busy, r_start_det, r_stop_det;

   i2c_line_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_cond (
      .clk        (clk),
      .reset      (reset),
      .i_scl      (scl_in),
      .i_sda      (sda_in),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_addr_match = (r_shift[7:1] == own_address) && (own_address != I2C_GENERAL_CALL);

   always_ff @(posedge clk) begin
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      if (reset) begin
         r_state   <= IDLE;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_sda_oe  <= 1'b0;
         r_rx_data <= '0;
         r_rw      <= 1'b0;
         r_busy    <= 1'b0;
      end else if (w_start) begin
         r_state     <= ADDR;
         r_bitcnt    <= '0;
         r_sda_oe    <= 1'b0;
         r_start_det <= 1'b1;
      end else if (w_stop) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_stop_det <= 1'b1;
      end else begin
         case (r_state)
            ADDR: begin
               if (w_scl_rise) begin
                  r_shift  <= {r_shift[6:0], w_sda};
                  r_bitcnt <= r_bitcnt + 1'b1;
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  if (w_addr_match) begin
                     r_sda_oe <= 1'b1;
                     r_rw     <= r_shift[0];
                     r_busy   <= 1'b1;
                     r_state  <= ADDR_ACK;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (w_scl_fall) begin
                  if (r_rw) begin
                     r_shift   <= tx_data;
                     r_tx_load <= 1'b1;
                     r_sda_oe  <= ~tx_data[7];
                     r_bitcnt  <= 4'd1;
                     r_state   <= TX_BYTE;
                  end else begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= '0;
                     r_state  <= RX_BYTE;
                  end
               end
            end
            RX_BYTE: begin
               if (w_scl_rise) begin
                  r_shift  <= {r_shift[6:0], w_sda};
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 4'd7) begin
                     r_rx_data  <= {r_shift[6:0], w_sda};
                     r_rx_valid <= 1'b1;
                  end
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  if (rx_ack_en) begin
                     r_sda_oe <= 1'b1;
                     r_state  <= RX_ACK;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= WAIT_STOP;
                  end
               end
            end
            RX_ACK: begin
               if (w_scl_fall) begin
                  r_sda_oe <= 1'b0;
                  r_bitcnt <= '0;
                  r_state  <= RX_BYTE;
               end
            end
            TX_BYTE: begin
               if (w_scl_fall) begin
                  if (r_bitcnt == 4'd8) begin
                     r_sda_oe <= 1'b0;
                     r_state  <= TX_ACK;
                  end else begin
                     r_shift  <= {r_shift[6:0], 1'b0};
                     r_sda_oe <= ~r_shift[6];
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
            end
            TX_ACK: begin
               // Only an ACKed rise leaves us here, so any fall means "send next byte".
               if (w_scl_rise && w_sda) begin
                  r_busy  <= 1'b0;
                  r_state <= WAIT_STOP;
               end else if (w_scl_fall) begin
                  r_shift   <= tx_data;
                  r_tx_load <= 1'b1;
                  r_sda_oe  <= ~tx_data[7];
                  r_bitcnt  <= 4'd1;
                  r_state   <= TX_BYTE;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_out    = 1'b0;
   assign sda_oe     = r_sda_oe;
   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign tx_load    = r_tx_load;
   assign read_write = r_rw;
   assign busy       = r_busy;
   assign start_det  = r_start_det;
   assign stop_det   = r_stop_det;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// +--------------------------------------------------------------------------+
// | tb_i2c_target : bus-level bench acting as an I2C controller around       |
// | i2c_target.  Revision: 1.0                                               |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target;
   import i2c_pkg::*;

   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 3;
   localparam int Q           = 15;   // quarter SCL period in clk cycles (~400 kHz)
`ifdef I2C_GLITCH_FILTER_EN
   localparam int EXP_LAT   = 1 + SYNC_STAGES + FILTER_LEN;
   localparam int EXP_SPIKE = 0;
`else
   localparam int EXP_LAT   = 1 + SYNC_STAGES;
   localparam int EXP_SPIKE = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_in = 1'b1;
   logic       ctrl_sda = 1'b1;
   logic       sda_in;
   logic       sda_out, sda_oe, rx_valid, tx_load, read_write, busy, start_det, stop_det;
   logic [6:0] own_address = 7'h42;
   logic       rx_ack_en = 1'b1;
   logic [7:0] rx_data;
   logic [7:0] tx_data = 8'h00;

   int n_assert = 0;
   int n_fail   = 0;
   int c_start = 0, c_stop = 0, c_txl = 0;
   logic [7:0] q_rx [$];

   assign sda_in = ctrl_sda & ~sda_oe;   // wired-AND open-drain bus

   i2c_target #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
      .sda_out(sda_out), .sda_oe(sda_oe), .own_address(own_address),
      .rx_ack_en(rx_ack_en), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .read_write(read_write),
      .busy(busy), .start_det(start_det), .stop_det(stop_det)
   );

   always #21 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (start_det) c_start++;
         if (stop_det)  c_stop++;
         if (tx_load)   c_txl++;
         if (rx_valid)  q_rx.push_back(rx_data);
      end
   end

   initial begin
      #(42 * 95000);
      $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // START from idle, or repeated START when SCL is low.
   task automatic start_cond();
      ctrl_sda = 1'b1; wait_clk(Q);
      scl_in   = 1'b1; wait_clk(Q);
      ctrl_sda = 1'b0; wait_clk(Q);
      scl_in   = 1'b0; wait_clk(Q);
   endtask

   task automatic stop_cond();
      ctrl_sda = 1'b0; wait_clk(Q);
      scl_in   = 1'b1; wait_clk(Q);
      ctrl_sda = 1'b1; wait_clk(Q);
   endtask

   task automatic write_bit(input logic b);
      ctrl_sda = b;    wait_clk(Q);
      scl_in   = 1'b1; wait_clk(2 * Q);
      scl_in   = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      ctrl_sda = 1'b1; wait_clk(Q);
      scl_in   = 1'b1; wait_clk(Q);
      b = sda_in;      wait_clk(Q);
      scl_in   = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_bits8(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
   endtask

   // Write transaction with up to 3 data bytes; expectations from the protocol rules.
   task automatic write_txn(input logic [6:0] addr, input logic ack_en,
                            input logic [23:0] data, input int nbytes);
      logic       ack, matched, active;
      logic [7:0] d;
      logic [7:0] exp_q [$];
      int         rx_base, s_base, p_base;
      rx_base = q_rx.size(); s_base = c_start; p_base = c_stop;
      rx_ack_en = ack_en;
      matched = (addr == own_address) && (addr != 7'h00);
      start_cond();
      write_byte({addr, 1'b0}, ack);
      check("addr_ack", ack, !matched);
      check("busy_after_addr", busy, matched);
      active = matched;
      for (int k = 0; k < nbytes; k++) begin
         d = data[23 - 8 * k -: 8];
         write_byte(d, ack);
         if (active) begin
            exp_q.push_back(d);
            check("data_ack", ack, !ack_en);
            if (!ack_en) active = 1'b0;
         end else begin
            check("data_nack_ignored", ack, 1'b1);
         end
      end
      if (!active) check("state_wait_stop", dut.r_state, WAIT_STOP);
      stop_cond();
      wait_clk(4);
      check("rx_count", q_rx.size() - rx_base, exp_q.size());
      for (int k = 0; k < exp_q.size() && rx_base + k < q_rx.size(); k++)
         check("rx_data", q_rx[rx_base + k], exp_q[k]);
      check("start_pulses", c_start - s_base, 1);
      check("stop_pulses", c_stop - p_base, 1);
      check("busy_after_stop", busy, 1'b0);
      check("state_idle", dut.r_state, IDLE);
   endtask

   // Read two bytes: controller ACKs the first and NACKs the second.
   task automatic read_txn(input logic [7:0] b0, input logic [7:0] b1);
      logic       ack;
      logic [7:0] d;
      int         t_base;
      t_base = c_txl;
      tx_data = b0;
      start_cond();
      write_byte({own_address, 1'b1}, ack);
      check("rd_addr_ack", ack, 1'b0);
      check("read_write", read_write, 1'b1);
      read_bits8(d);
      check("rd_byte0", d, b0);
      tx_data = b1;
      write_bit(1'b0);
      read_bits8(d);
      check("rd_byte1", d, b1);
      check("busy_before_nack", busy, 1'b1);
      write_bit(1'b1);
      check("busy_after_nack", busy, 1'b0);
      check("tx_load_pulses", c_txl - t_base, 2);
      stop_cond();
      wait_clk(4);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         lat, base, pbase, rbase;

      // Reset state
      wait_clk(5);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_sda_out", sda_out, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_tx_load", tx_load, 1'b0);
      check("rst_read_write", read_write, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_start_det", start_det, 1'b0);
      check("rst_stop_det", stop_det, 1'b0);
      check("rst_state", dut.r_state, IDLE);
      reset = 1'b0;
      wait_clk(Q);

      // START latency, measured from the SDA pin edge
      ctrl_sda = 1'b0;
      lat = 0;
      while (!start_det && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("start_latency", lat, EXP_LAT);
      wait_clk(Q);
      scl_in = 1'b0; wait_clk(Q);
      stop_cond();
      wait_clk(4);

      // Directed write 0x84, 0xA5, 0x3C
      write_txn(7'h42, 1'b1, 24'hA53C00, 2);
      // Directed read with 0x5A on both bytes
      read_txn(8'h5A, 8'h5A);
      // Address 0x48 not ours
      write_txn(7'h48, 1'b1, 24'h550000, 1);
      // General call never matched, even with own address 0
      own_address = 7'h00;
      write_txn(7'h00, 1'b1, 24'h120000, 1);
      own_address = 7'h42;
      // Data NACK path
      write_txn(7'h42, 1'b0, 24'hC3_7E_00, 2);

      // Write then repeated START into a read
      rbase = q_rx.size(); base = c_txl;
      rx_ack_en = 1'b1;
      tx_data = 8'h96;
      start_cond();
      write_byte(8'h84, ack); check("rs_addr_w_ack", ack, 1'b0);
      write_byte(8'h11, ack); check("rs_data_ack", ack, 1'b0);
      start_cond();
      write_byte(8'h85, ack); check("rs_addr_r_ack", ack, 1'b0);
      check("rs_read_write", read_write, 1'b1);
      check("rs_tx_load", c_txl - base, 1);
      read_bits8(d); check("rs_rd_byte", d, 8'h96);
      write_bit(1'b1);
      stop_cond();
      wait_clk(4);
      check("rs_rx_count", q_rx.size() - rbase, 1);
      if (q_rx.size() > rbase) check("rs_rx_data", q_rx[rbase], 8'h11);

      // Randomised transactions
      for (int n = 0; n < 4; n++) begin
         own_address = 7'($urandom_range(1, 127));
         write_txn(($urandom_range(0, 2) != 0) ? own_address : 7'($urandom),
                   1'($urandom_range(0, 3) != 0), 24'($urandom), 3);
      end
      own_address = 7'h42;
      for (int n = 0; n < 2; n++) read_txn(8'($urandom), 8'($urandom));

      // Reset while the target drives the address ACK
      start_cond();
      for (int i = 7; i >= 0; i--) write_bit(1'(8'h84 >> i));
      ctrl_sda = 1'b1;
      wait_clk(2);
      check("ack_driven_oe", sda_oe, 1'b1);
      check("ack_driven_bus", sda_in, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_sda_oe", sda_oe, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_state", dut.r_state, IDLE);
      reset = 1'b0;
      wait_clk(2);
      stop_cond();
      wait_clk(Q);

      // Two-cycle SDA spike while SCL is high
      base = c_start; pbase = c_stop;
      ctrl_sda = 1'b0;
      wait_clk(2);
      ctrl_sda = 1'b1;
      wait_clk(20);
      check("spike_start", c_start - base, EXP_SPIKE);
      check("spike_stop", c_stop - pbase, EXP_SPIKE);
      check("spike_state", dut.r_state, IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
